// File: rtl/start_done_initiator_if.sv
// Batch command, worker start/ready/done and status bundle.
// master = initiator side, slave = upstream sequencer plus worker.
interface start_done_initiator_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_ready;
    logic             dev_start;
    logic             dev_ready;
    logic             dev_done;
    logic             busy;
    logic             batch_done;
    logic [CNT_W-1:0] jobs_completed;
    logic             err_timeout;

    modport master (
        input  cmd_valid, cmd_count,
        input  dev_ready, dev_done,
        output cmd_ready, dev_start,
        output busy, batch_done,
        output jobs_completed, err_timeout
    );

    modport slave (
        output cmd_valid, cmd_count,
        output dev_ready, dev_done,
        input  cmd_ready, dev_start,
        input  busy, batch_done,
        input  jobs_completed, err_timeout
    );
endinterface

// File: rtl/start_done_initiator.sv
// Start/ready/done initiator: runs a batch of jobs on one worker.
// Optional per-job timeout: START_DONE_INITIATOR_TIMEOUT_EN.
module start_done_initiator #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    start_done_initiator_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACCEPT,
        S_WAIT,
        S_FINISH
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] jobs_q, jobs_d;
    logic             dev_start_q, dev_start_d;
    logic             batch_done_q, batch_done_d;

    logic accept;
    logic launch;
    logic job_done;
    logic last_job;
    logic timeout_fire;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign accept   = (state_q == S_IDLE) && bus.cmd_valid;
    assign launch   = (state_q == S_ISSUE) && bus.dev_ready;
    assign job_done = (state_q == S_WAIT)
                    && bus.dev_done && bus.dev_ready;
    assign last_job = (remaining_q == CNT_W'(1));

`ifdef START_DONE_INITIATOR_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2)
                      ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          in_job;
    logic          progress;

    assign in_job   = (state_q == S_ACCEPT) || (state_q == S_WAIT);
    assign progress = ((state_q == S_ACCEPT) && !bus.dev_ready)
                    || job_done;
    assign timeout_fire = in_job && !progress && (timer_q == LIMIT);

    // Job timer restarts on each start and saturates at the limit;
    // the error flag is sticky until the next batch is accepted.
    always_comb begin
        timer_d = timer_q;
        err_d   = err_q;
        if (launch) begin
            timer_d = '0;
        end else if (in_job && (timer_q != LIMIT)) begin
            timer_d = timer_q + TW'(1);
        end
        if (accept) begin
            err_d = 1'b0;
        end else if (timeout_fire) begin
            err_d = 1'b1;
        end
    end

    // Timer and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign timeout_fire    = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a stale done in ACCEPT is ignored because the
    // worker has not yet shown it took the job (ready still high).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = (bus.cmd_count == '0)
                            ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.dev_ready) begin
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (!bus.dev_ready) begin
                    state_d = S_WAIT;
                end else if (timeout_fire) begin
                    state_d = S_FINISH;
                end
            end
            S_WAIT: begin
                if (job_done) begin
                    state_d = last_job ? S_FINISH : S_ISSUE;
                end else if (timeout_fire) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Registered outputs and job counters; batch_done is high for
    // the single cycle spent in FINISH.
    always_comb begin
        dev_start_d  = launch;
        batch_done_d = (state_d == S_FINISH);
        remaining_d  = remaining_q;
        jobs_d       = jobs_q;
        if (accept) begin
            jobs_d      = '0;
            remaining_d = bus.cmd_count;
        end else if (job_done) begin
            jobs_d      = jobs_q + CNT_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dev_start_q  <= 1'b0;
            batch_done_q <= 1'b0;
            remaining_q  <= '0;
            jobs_q       <= '0;
        end else begin
            dev_start_q  <= dev_start_d;
            batch_done_q <= batch_done_d;
            remaining_q  <= remaining_d;
            jobs_q       <= jobs_d;
        end
    end

    assign bus.cmd_ready      = (state_q == S_IDLE);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.dev_start      = dev_start_q;
    assign bus.batch_done     = batch_done_q;
    assign bus.jobs_completed = jobs_q;

endmodule

// File: tb/tb_start_done_initiator.sv
// Bench for start_done_initiator: random batches against a
// behavioural worker and a per-batch expectation model.
`timescale 1ns/1ps
module tb_start_done_initiator;

    localparam int CNT_W = 8;
    localparam int TO    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             cmd_valid = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             dev_ready = 1'b1;
    logic             dev_done  = 1'b0;

    start_done_initiator_if #(.CNT_W(CNT_W)) bus ();

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_count = cmd_count;
    assign bus.dev_ready = dev_ready;
    assign bus.dev_done  = dev_done;

    start_done_initiator #(
        .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // worker model state
    int w_phase    = 0;
    int w_cnt      = 0;
    bit w_hang     = 0;
    int lat_lo     = 1;
    int lat_hi     = 4;
    int stall_cnt  = 0;
    int hang_at    = 0;
    int starts     = 0;
    int bd_cnt     = 0;
    int last_done  = 0;
    int first_start = 0;
    bit prev_start = 0;
    int prev_jobs  = 0;

    // Worker: takes a start, keeps ready high 0-2 cycles, drops
    // ready for a random latency, then raises done and ready.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                w_phase    = 0;
                w_hang     = 0;
                dev_ready  = 1'b1;
                dev_done   = 1'b0;
                prev_start = 0;
            end else begin
                if (bus.batch_done) bd_cnt++;
                if (bus.dev_start) begin
                    chk("start_pulse", 32'(prev_start), 0);
                    chk("start_rdy",
                        {30'd0, w_phase == 0, dev_ready}, 3);
                    if (starts > 0)
                        chk("start_gap", 32'((cyc - last_done) >= 2), 1);
                    else
                        first_start = cyc;
                    starts++;
                    if (starts == hang_at) w_hang = 1;
                    w_cnt = $urandom_range(0, 2);
                    if (w_cnt == 0) begin
                        dev_ready = 1'b0;
                        dev_done  = 1'($urandom % 2);
                        w_cnt     = $urandom_range(lat_lo, lat_hi);
                        w_phase   = 2;
                    end else begin
                        w_phase = 1;
                    end
                end else begin
                    case (w_phase)
                        0: begin
                            if (stall_cnt > 0) begin
                                dev_ready = 1'b0;
                                stall_cnt--;
                            end else begin
                                dev_ready = 1'b1;
                            end
                        end
                        1: begin
                            w_cnt--;
                            dev_done = 1'($urandom % 2);
                            if (w_cnt == 0) begin
                                dev_ready = 1'b0;
                                w_cnt     = $urandom_range(lat_lo, lat_hi);
                                w_phase   = 2;
                            end
                        end
                        default: begin
                            if (!w_hang) w_cnt--;
                            if (w_cnt == 0) begin
                                dev_ready = 1'b1;
                                dev_done  = 1'b1;
                                last_done = cyc;
                                w_phase   = 0;
                            end else begin
                                dev_done = 1'($urandom % 2);
                            end
                        end
                    endcase
                end
                prev_start = bus.dev_start;
            end
        end
    end

    task automatic chk_reset_outs();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_dev_start", 32'(bus.dev_start), 0);
        chk("rst_batch_done", 32'(bus.batch_done), 0);
        chk("rst_jobs", 32'(bus.jobs_completed), 0);
        chk("rst_err", 32'(bus.err_timeout), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk_reset_outs();
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_bd", 32'(bus.batch_done), 0);
        end
        rst       = 1'b0;
        stall_cnt = 0;
        hang_at   = 0;
        prev_jobs = 0;
    endtask

    // One batch: expected jobs/starts follow from the count and from
    // which job (if any) the worker never finishes.
    task automatic run_batch(input int n, input int hang, input int stall);
        int t0;
        int limit;
        int exp_jobs;
        int exp_starts;
        bit seen;
        exp_jobs   = (hang > 0) ? hang - 1 : n;
        exp_starts = (hang > 0) ? hang : n;
        stall_cnt  = stall;
        @(negedge clk);
        chk("idle_rdy", 32'(bus.cmd_ready), 1);
        chk("held_jobs", 32'(bus.jobs_completed), 32'(prev_jobs));
        cmd_valid = 1'b1;
        cmd_count = CNT_W'(n);
        starts    = 0;
        bd_cnt    = 0;
        hang_at   = hang;
        t0        = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_acc", 32'(bus.busy), 1);
        chk("err_clr", 32'(bus.err_timeout), 0);
        chk("jc_clr", 32'(bus.jobs_completed), 0);
        limit = 100 + n * 16 + stall;
        seen  = 0;
        for (int i = 0; i < limit; i++) begin
            if (bus.batch_done) begin
                seen = 1;
                break;
            end
            cmd_valid = 1'($urandom % 2);
            cmd_count = CNT_W'($urandom);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("bd_seen", 32'(seen), 1);
        if (seen) begin
            chk("jobs", 32'(bus.jobs_completed), 32'(exp_jobs));
            chk("starts", 32'(starts), 32'(exp_starts));
            chk("err", 32'(bus.err_timeout), (hang > 0) ? 1 : 0);
            chk("bd_busy", {30'd0, bus.cmd_ready, bus.busy}, 1);
            if (n == 0)
                chk("zero_lat", 32'(cyc - t0), 1);
            else if (hang == 0)
                chk("bd_lat", 32'(cyc - last_done), 1);
            if (stall > 0 && n > 0)
                chk("stall_gap", 32'((first_start - t0) >= stall), 1);
            @(negedge clk);
            chk("ret_idle",
                {29'd0, bus.cmd_ready, bus.busy, bus.batch_done}, 4);
            chk("bd_once", 32'(bd_cnt), 1);
            prev_jobs = exp_jobs;
        end
        if (hang > 0) begin
            w_hang    = 0;
            w_phase   = 0;
            dev_ready = 1'b1;
            dev_done  = 1'b0;
            hang_at   = 0;
        end
        if (!seen) pulse_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs();

        lat_lo = 3;
        lat_hi = 3;
        run_batch(1, 0, 0);
        run_batch(5, 0, 0);
        run_batch(0, 0, 0);
        run_batch(1, 0, 10);

        lat_lo = 4;
        lat_hi = 4;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_count = CNT_W'(3);
        starts    = 0;
        bd_cnt    = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            if (w_phase == 2) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_wait_reached", 32'(got), 1);
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 1);
        pulse_reset();
        chk("rst_bd_cnt", 32'(bd_cnt), 0);
        run_batch(2, 0, 0);

        lat_lo = 1;
        lat_hi = 4;
        for (int i = 0; i < 25; i++) begin
            int n;
            int s;
            n = $urandom_range(0, 7);
            s = ($urandom % 4 == 0) ? $urandom_range(1, 6) : 0;
            run_batch(n, 0, s);
        end

        lat_lo = 1;
        lat_hi = 1;
        run_batch(255, 0, 0);

`ifdef START_DONE_INITIATOR_TIMEOUT_EN
        lat_lo = 1;
        lat_hi = 4;
        run_batch(3, 2, 0);
        run_batch(2, 0, 0);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
